// File: rtl/panda_risc_v_pkg.sv
// Shared definitions for the long-instruction scoreboard: instruction type
// codes and the default table geometry.
package panda_risc_v_pkg;

  localparam int LONG_INST_N_DEFAULT = 4;
  localparam int LI_TID_W_DEFAULT    = 3;

  localparam logic [2:0] LI_TYPE_LOAD  = 3'd0;
  localparam logic [2:0] LI_TYPE_STORE = 3'd1;
  localparam logic [2:0] LI_TYPE_MUL   = 3'd2;
  localparam logic [2:0] LI_TYPE_DIV   = 3'd3;
  localparam logic [2:0] LI_TYPE_CSR   = 3'd4;

  function automatic logic li_is_ls(input logic [2:0] li_type);
    return (li_type == LI_TYPE_LOAD) || (li_type == LI_TYPE_STORE);
  endfunction

endpackage

// File: rtl/panda_risc_v_lowest_free_sel.sv
// Priority encoder: returns the lowest set bit of free_vec_i and whether any
// bit is set. The index is 0 when nothing is free.
module panda_risc_v_lowest_free_sel #(
  parameter int N     = 4,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     free_vec_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    found_o = |free_vec_i;
    idx_o   = '0;
    // Scan downward so the lowest free index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (free_vec_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/panda_risc_v_long_inst_scoreboard.sv
// Scoreboard of outstanding long instructions (load/store/mul/div/csr) between
// dispatch and writeback; supplies entry IDs and WAW/RAW hazard flags.
module panda_risc_v_long_inst_scoreboard
  import panda_risc_v_pkg::*;
#(
  parameter int LONG_INST_N = LONG_INST_N_DEFAULT,
  parameter int TID_W       = LI_TID_W_DEFAULT
) (
  input  logic             clk,
  input  logic             sys_resetn,
  input  logic             sys_reset_req,
  input  logic [4:0]       waw_check_rd_id,
  output logic             rd_waw_dpc,
  input  logic [4:0]       raw_check_rs1_id,
  input  logic [4:0]       raw_check_rs2_id,
  output logic             rs1_raw_dpc,
  output logic             rs2_raw_dpc,
  input  logic [4:0]       s_alloc_rd_id,
  input  logic             s_alloc_rd_vld,
  input  logic [2:0]       s_alloc_type,
  input  logic             s_alloc_valid,
  output logic             s_alloc_ready,
  output logic [TID_W-1:0] s_alloc_tid,
  input  logic [TID_W-1:0] s_wb_tid,
  input  logic             s_wb_valid,
  output logic [TID_W:0]   long_inst_cnt,
  output logic             ls_pending,
  output logic             table_empty
);

  localparam int N = LONG_INST_N;

  logic [N-1:0]   vld_q, vld_d;
  logic [N-1:0]   rd_vld_q, rd_vld_d;
  logic [N*5-1:0] rd_id_q, rd_id_d;
  logic [N*3-1:0] type_q, type_d;
  logic [TID_W:0] cnt_q, cnt_d;

  logic             free_found;
  logic [TID_W-1:0] free_idx;
  logic             alloc_fire;
  logic [N-1:0]     alloc_hit, wb_hit;
  logic [N-1:0]     waw_hit, rs1_hit, rs2_hit, ls_hit;

  panda_risc_v_lowest_free_sel #(
    .N    (N),
    .IDX_W(TID_W)
  ) u_free_sel (
    .free_vec_i(~vld_q),
    .found_o   (free_found),
    .idx_o     (free_idx)
  );

  // Ready/tid come only from registered state, so a same-cycle retire never
  // makes its entry available before the next edge.
  assign s_alloc_ready = free_found;
  assign s_alloc_tid   = free_idx;
  assign alloc_fire    = s_alloc_valid & free_found;

  for (genvar gi = 0; gi < N; gi++) begin : g_entry
    logic [4:0] rd_id_e;
    assign rd_id_e = rd_id_q[gi*5 +: 5];

    assign alloc_hit[gi] = alloc_fire && (free_idx == TID_W'(gi));
    // Retires of free entries (or of tids beyond the table) match nothing.
    assign wb_hit[gi]    = s_wb_valid && (s_wb_tid == TID_W'(gi)) && vld_q[gi];

    assign vld_d[gi]          = alloc_hit[gi] | (vld_q[gi] & ~wb_hit[gi]);
    assign rd_vld_d[gi]       = alloc_hit[gi] ? s_alloc_rd_vld : rd_vld_q[gi];
    assign rd_id_d[gi*5 +: 5] = alloc_hit[gi] ? s_alloc_rd_id  : rd_id_e;
    assign type_d[gi*3 +: 3]  = alloc_hit[gi] ? s_alloc_type   : type_q[gi*3 +: 3];

    // A retiring entry still matches this cycle, which is the safe direction.
    assign waw_hit[gi] = vld_q[gi] & rd_vld_q[gi] & (rd_id_e == waw_check_rd_id);
    assign rs1_hit[gi] = vld_q[gi] & rd_vld_q[gi] & (rd_id_e == raw_check_rs1_id);
    assign rs2_hit[gi] = vld_q[gi] & rd_vld_q[gi] & (rd_id_e == raw_check_rs2_id);
    assign ls_hit[gi]  = vld_q[gi] & li_is_ls(type_q[gi*3 +: 3]);
  end

  assign cnt_d = cnt_q + {{TID_W{1'b0}}, alloc_fire} - {{TID_W{1'b0}}, |wb_hit};

  always_ff @(posedge clk) begin
    if (!sys_resetn || sys_reset_req) begin
      vld_q    <= '0;
      rd_vld_q <= '0;
      rd_id_q  <= '0;
      type_q   <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      rd_vld_q <= rd_vld_d;
      rd_id_q  <= rd_id_d;
      type_q   <= type_d;
      cnt_q    <= cnt_d;
    end
  end

  // x0 is hard-wired zero and never creates a hazard.
  assign rd_waw_dpc    = (waw_check_rd_id  != 5'd0) & (|waw_hit);
  assign rs1_raw_dpc   = (raw_check_rs1_id != 5'd0) & (|rs1_hit);
  assign rs2_raw_dpc   = (raw_check_rs2_id != 5'd0) & (|rs2_hit);
  assign long_inst_cnt = cnt_q;
  assign ls_pending    = |ls_hit;
  assign table_empty   = ~(|vld_q);

endmodule

// File: tb/tb_panda_risc_v_long_inst_scoreboard.sv
// Self-checking bench: directed scenarios then random traffic, each cycle
// compared against an array-based model of the outstanding-instruction table.
module tb_panda_risc_v_long_inst_scoreboard;
  import panda_risc_v_pkg::*;

  localparam int N  = 4;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          sys_resetn, sys_reset_req;
  logic [4:0]    waw_check_rd_id, raw_check_rs1_id, raw_check_rs2_id;
  logic          rd_waw_dpc, rs1_raw_dpc, rs2_raw_dpc;
  logic [4:0]    s_alloc_rd_id;
  logic          s_alloc_rd_vld;
  logic [2:0]    s_alloc_type;
  logic          s_alloc_valid, s_alloc_ready;
  logic [TW-1:0] s_alloc_tid, s_wb_tid;
  logic          s_wb_valid;
  logic [TW:0]   long_inst_cnt;
  logic          ls_pending, table_empty;

  always #5 clk = ~clk;

  panda_risc_v_long_inst_scoreboard #(.LONG_INST_N(N), .TID_W(TW)) dut (
    .clk             (clk),
    .sys_resetn      (sys_resetn),
    .sys_reset_req   (sys_reset_req),
    .waw_check_rd_id (waw_check_rd_id),
    .rd_waw_dpc      (rd_waw_dpc),
    .raw_check_rs1_id(raw_check_rs1_id),
    .raw_check_rs2_id(raw_check_rs2_id),
    .rs1_raw_dpc     (rs1_raw_dpc),
    .rs2_raw_dpc     (rs2_raw_dpc),
    .s_alloc_rd_id   (s_alloc_rd_id),
    .s_alloc_rd_vld  (s_alloc_rd_vld),
    .s_alloc_type    (s_alloc_type),
    .s_alloc_valid   (s_alloc_valid),
    .s_alloc_ready   (s_alloc_ready),
    .s_alloc_tid     (s_alloc_tid),
    .s_wb_tid        (s_wb_tid),
    .s_wb_valid      (s_wb_valid),
    .long_inst_cnt   (long_inst_cnt),
    .ls_pending      (ls_pending),
    .table_empty     (table_empty)
  );

  // Reference table: one slot per entry ID.
  bit m_vld [N];
  bit m_rdv [N];
  int m_rd  [N];
  int m_typ [N];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_free_tid();
    for (int i = 0; i < N; i++) if (!m_vld[i]) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_vld[i];
    return c;
  endfunction

  function automatic bit m_dep(input int id);
    if (id == 0) return 1'b0;
    for (int i = 0; i < N; i++) if (m_vld[i] && m_rdv[i] && m_rd[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ls();
    for (int i = 0; i < N; i++)
      if (m_vld[i] && (m_typ[i] == int'(LI_TYPE_LOAD) || m_typ[i] == int'(LI_TYPE_STORE))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_vld_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_vld[i];
    return v;
  endfunction

  // One clock: drive, compare all outputs before the edge, then advance the model.
  task automatic cycle(input bit av, input bit arv, input int ard, input int atyp,
                       input bit wv, input int wtid, input bit rreq, input bit rstn,
                       input int cw, input int c1, input int c2);
    int  ft;
    bit  fire;
    s_alloc_valid    = av;
    s_alloc_rd_vld   = arv;
    s_alloc_rd_id    = 5'(ard);
    s_alloc_type     = 3'(atyp);
    s_wb_valid       = wv;
    s_wb_tid         = TW'(wtid);
    sys_reset_req    = rreq;
    sys_resetn       = rstn;
    waw_check_rd_id  = 5'(cw);
    raw_check_rs1_id = 5'(c1);
    raw_check_rs2_id = 5'(c2);
    @(negedge clk);
    ft = m_free_tid();
    check_eq("alloc_ready", 32'(s_alloc_ready), 32'(ft >= 0));
    check_eq("alloc_tid",   32'(s_alloc_tid),   32'((ft >= 0) ? ft : 0));
    check_eq("cnt",         32'(long_inst_cnt), 32'(m_count()));
    check_eq("empty",       32'(table_empty),   32'(m_count() == 0));
    check_eq("ls_pending",  32'(ls_pending),    32'(m_ls()));
    check_eq("waw",         32'(rd_waw_dpc),    32'(m_dep(cw)));
    check_eq("rs1_raw",     32'(rs1_raw_dpc),   32'(m_dep(c1)));
    check_eq("rs2_raw",     32'(rs2_raw_dpc),   32'(m_dep(c2)));
    fire = av && (ft >= 0);
    assert (!(fire && wv && wtid == ft && m_vld[ft]))
      else $error("alloc and retire hit the same live tid %0d", ft);
    $display("cyc alloc=%0b fire=%0b tid=%0d rd=%0d type=%0d wb=%0b wtid=%0d rreq=%0b rstn=%0b cnt=%0d",
             av, fire, ft, ard, atyp, wv, wtid, rreq, rstn, m_count());
    @(posedge clk);
    if (!rstn || rreq) begin
      for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
    end else begin
      if (wv && wtid < N && m_vld[wtid]) m_vld[wtid] = 1'b0;
      if (fire) begin
        m_vld[ft] = 1'b1;
        m_rdv[ft] = arv;
        m_rd[ft]  = ard;
        m_typ[ft] = atyp;
      end
    end
    #1;
  endtask

  task automatic idle(input int cw, input int c1, input int c2);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, cw, c1, c2);
  endtask

  initial begin
    sys_resetn = 1'b0; sys_reset_req = 1'b0;
    s_alloc_valid = 1'b0; s_alloc_rd_vld = 1'b0; s_alloc_rd_id = '0; s_alloc_type = '0;
    s_wb_valid = 1'b0; s_wb_tid = '0;
    waw_check_rd_id = '0; raw_check_rs1_id = '0; raw_check_rs2_id = '0;
    repeat (2) @(posedge clk);
    #1;

    idle(5, 6, 7);
    check_eq("rst_ready", 32'(s_alloc_ready), 32'd1);
    check_eq("rst_tid",   32'(s_alloc_tid),   32'd0);
    check_eq("rst_empty", 32'(table_empty),   32'd1);
    check_eq("rst_cnt",   32'(long_inst_cnt), 32'd0);

    cycle(1, 1, 5, LI_TYPE_LOAD, 0, 0, 0, 1, 5, 6, 7);
    check_eq("plan_tid1", 32'(s_alloc_tid), 32'd1);
    cycle(1, 1, 7, LI_TYPE_MUL, 0, 0, 0, 1, 5, 6, 7);
    idle(5, 6, 7);
    check_eq("plan_cnt2", 32'(long_inst_cnt), 32'd2);
    check_eq("plan_ls",   32'(ls_pending),    32'd1);
    check_eq("plan_waw5", 32'(rd_waw_dpc),    32'd1);
    check_eq("plan_rs2",  32'(rs2_raw_dpc),   32'd1);
    check_eq("plan_rs1",  32'(rs1_raw_dpc),   32'd0);

    cycle(1, 1, 9,  LI_TYPE_DIV, 0, 0, 0, 1, 9, 10, 0);
    cycle(1, 1, 10, LI_TYPE_CSR, 0, 0, 0, 1, 9, 10, 0);
    check_eq("full_ready", 32'(s_alloc_ready), 32'd0);
    cycle(1, 1, 12, LI_TYPE_LOAD, 1, 2, 0, 1, 12, 9, 10);
    check_eq("freed_ready", 32'(s_alloc_ready), 32'd1);
    check_eq("freed_tid",   32'(s_alloc_tid),   32'd2);
    check_eq("freed_cnt",   32'(long_inst_cnt), 32'd3);

    cycle(0, 0, 0, 0, 1, 1, 0, 1, 7, 0, 0);
    cycle(0, 0, 0, 0, 1, 3, 0, 1, 7, 0, 0);
    cycle(1, 1, 11, LI_TYPE_MUL, 0, 0, 0, 1, 11, 5, 0);
    cycle(1, 1, 13, LI_TYPE_STORE, 1, 0, 0, 1, 13, 5, 11);
    check_eq("swap_cnt", 32'(long_inst_cnt), 32'd2);
    check_eq("swap_vld", 32'(dut.vld_q),     32'h6);

    cycle(0, 0, 0, 0, 1, 0, 0, 1, 5, 11, 13);
    cycle(0, 0, 0, 0, 1, 5, 0, 1, 5, 11, 13);
    check_eq("bogus_cnt", 32'(long_inst_cnt), 32'd2);
    check_eq("bogus_vld", 32'(dut.vld_q),     m_vld_vec());

    cycle(1, 1, 0, LI_TYPE_STORE, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 0, 0);
    check_eq("x0_waw", 32'(rd_waw_dpc),    32'd0);
    check_eq("x0_cnt", 32'(long_inst_cnt), 32'd3);

    cycle(1, 1, 3, LI_TYPE_LOAD, 0, 0, 0, 1, 3, 0, 0);
    check_eq("full2_ready", 32'(s_alloc_ready), 32'd0);
    cycle(0, 0, 0, 0, 1, 1, 1, 1, 3, 11, 13);
    check_eq("clr_cnt",   32'(long_inst_cnt), 32'd0);
    check_eq("clr_empty", 32'(table_empty),   32'd1);
    check_eq("clr_ready", 32'(s_alloc_ready), 32'd1);
    idle(3, 11, 13);

    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 9) < 6,
            $urandom_range(0, 3) != 0,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)),
            $urandom_range(0, 4),
            $urandom_range(0, 1),
            $urandom_range(0, 7),
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 99) != 0,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/panda_risc_v_long_inst_scoreboard.md
# panda_risc_v_long_inst_scoreboard

Tracks every long instruction (load, store, multiply, divide/remainder, CSR read-write) between dispatch and writeback. Holds one entry per outstanding long instruction and assigns it an entry ID. Returns WAW/RAW dependency flags to the dispatcher and decoder. Sits beside the dispatcher: entries are allocated on a long-instruction dispatch handshake and released when the instruction writes back.

## Interface
- LONG_INST_N, 4, number of table entries (2..8)
- TID_W, 3, entry ID width; must satisfy 2^TID_W ≥ LONG_INST_N
- clk  input  1  clock
- sys_resetn  input  1  reset; synchronous and active-low
- sys_reset_req  input  1  system reset request; clears the table
- waw_check_rd_id  input  5  RD index of the pending dispatch
- rd_waw_dpc  output  1  a valid entry has RD == waw_check_rd_id
- raw_check_rs1_id / raw_check_rs2_id  input  5 each  source indices from the decoder
- rs1_raw_dpc / rs2_raw_dpc  output  1 each  a valid entry with rd_vld has RD == RSx
- s_alloc_rd_id  input  5  RD of the instruction being dispatched
- s_alloc_rd_vld  input  1  instruction writes RD
- s_alloc_type  input  3  LI_TYPE_LOAD/STORE/MUL/DIV/CSR
- s_alloc_valid  input  1  long-instruction dispatch request
- s_alloc_ready  output  1  at least one free entry
- s_alloc_tid  output  TID_W  ID of the entry that will be allocated
- s_wb_tid  input  TID_W  entry being retired
- s_wb_valid  input  1  retire strobe
- long_inst_cnt  output  TID_W+1  number of valid entries
- ls_pending  output  1  any valid LOAD/STORE entry
- table_empty  output  1  no valid entry

## Operation
- Per-entry registered state: vld, rd_vld, rd_id[4:0], type[2:0].
- Allocation:
  - Fires when s_alloc_valid & s_alloc_ready.
  - Writes the entry at s_alloc_tid: vld=1, rd_vld, rd_id, type.
  - s_alloc_tid is the lowest-index entry with vld=0 in the current registered state. When the table is full it is 0 and s_alloc_ready=0.
  - s_alloc_ready depends on registered state only, never on s_alloc_valid.
- Retire:
  - s_wb_valid clears vld of entry s_wb_tid.
  - Retiring an entry with vld=0, or with tid ≥ LONG_INST_N, is ignored; no state changes.
- Dependency checks:
  - Combinational on registered state.
  - Index 0 never matches, so all flags are 0 for x0.
  - An entry retiring in the current cycle still matches in that cycle (conservative).
  - rd_waw_dpc matches only entries with rd_vld=1.
- Counters and flags:
  - long_inst_cnt = popcount(vld), registered and updated alongside the table.
  - ls_pending and table_empty are derived from vld and type.
- Flush: flush_req has no effect. Dispatched long instructions are older than the flush and always write back.

## Timing
- Reset (sys_resetn=0 at a clk edge) or sys_reset_req=1: all vld=0 and long_inst_cnt=0 on the next edge. Both have priority over same-cycle allocate or retire.
- Reset values of outputs: s_alloc_ready=1, s_alloc_tid=0, rd_waw_dpc=rs1_raw_dpc=rs2_raw_dpc=0, long_inst_cnt=0, ls_pending=0, table_empty=1.
- An allocation is visible in flags and count one cycle after the handshake edge.
- A retirement is visible one cycle after the strobe edge.
- Allocate and retire in the same cycle:
  - Both take effect; long_inst_cnt is unchanged.
  - The freed entry is not reusable until the following cycle.
  - A full table with a same-cycle retire keeps s_alloc_ready=0 in that cycle.
- Allocate and retire on the same tid in the same cycle cannot occur, because the allocated tid is always free. The bench asserts this.

## Structure
- Shared package panda_risc_v_pkg holds:
  - LI_TYPE_LOAD=3'd0, LI_TYPE_STORE=3'd1, LI_TYPE_MUL=3'd2, LI_TYPE_DIV=3'd3, LI_TYPE_CSR=3'd4.
  - The default LONG_INST_N.
- One sub-module, panda_risc_v_lowest_free_sel: a parameterized priority encoder from the ~vld vector to {found, index}.
- Entry state is flat vectors; no RAM.

## Test plan
- Reset → s_alloc_ready=1, s_alloc_tid=0, table_empty=1, long_inst_cnt=0, all dependency flags 0.
- Allocate LOAD rd=5, then MUL rd=7 → tids 0 and 1. Next cycle: long_inst_cnt=2, ls_pending=1, rd_waw_dpc=1 for check id 5, rs2_raw_dpc=1 for rs2=7, rs1_raw_dpc=0 for rs1=6.
- Fill all 4 entries → s_alloc_ready=0. Retire tid 2 and allocate in the same cycle → no handshake; next cycle s_alloc_tid=2 and ready=1.
- With 2 entries valid, allocate tid 2 while retiring tid 0 in the same cycle → long_inst_cnt stays 2; next cycle vld = 4'b0110.
- Retire a tid with vld=0, and retire tid=5 with LONG_INST_N=4 → state unchanged. Allocate with rd=0 → rd_waw_dpc stays 0 for id 0.
- Table full, then sys_reset_req=1 concurrent with s_wb_valid → next cycle all entries cleared, table_empty=1, long_inst_cnt=0.
